// File: rtl/pipeline_elastic_stage.sv
// Elastic pipeline stage: a small circular buffer between a valid/ready
// producer and consumer. in_ready is decoded from the registered occupancy
// only, so no combinational path runs from out_ready back to in_ready.
// A full buffer therefore accepts nothing on the cycle it drains; in_ready
// rises on the following cycle.
module pipeline_elastic_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full_n;
    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    // Handshake qualification; flush wins over both sides of the buffer.
    always_comb begin
        w_full_n     = (r_count < DEPTH_C);
        w_not_empty  = (r_count != '0);
        w_push       = in_valid  && w_full_n    && !flush;
        w_pop        = out_ready && w_not_empty && !flush;
        w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
        w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
    end

    // Payload storage; not reset because out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy state with async clear and synchronous flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Output decode from registered state; head payload forced to zero when empty.
    always_comb begin
        in_ready  = w_full_n;
        out_valid = w_not_empty;
        out_data  = w_not_empty ? r_mem[r_rd_ptr] : '0;
        count     = r_count;
    end

endmodule

// File: doc/pipeline_elastic_stage.md
PIPELINE_ELASTIC_STAGE -- requirements
Module: pipeline_elastic_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning payload bit width (≥1).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning buffer entries (power of two, ≥2).
REQ-003 The block SHALL have parameter CW, default $clog2(DEPTH+1), meaning occupancy counter width.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 The block SHALL have port flush  input  1  meaning synchronous discard of all buffered entries.
REQ-007 The block SHALL have port in_valid  input  1  meaning upstream offers in_data this cycle.
REQ-008 The block SHALL have port in_data  input  WIDTH  meaning upstream payload.
REQ-009 The block SHALL have port in_ready  output  1  meaning the block accepts a beat this cycle.
REQ-010 The block SHALL have port out_valid  output  1  meaning out_data holds a valid head entry.
REQ-011 The block SHALL have port out_data  output  WIDTH  meaning the head entry payload.
REQ-012 The block SHALL have port out_ready  input  1  meaning downstream consumes the head this cycle.
REQ-013 The block SHALL have port count  output  CW  meaning current number of buffered entries (0..DEPTH).

Function
REQ-014 Enqueue SHALL occur on a rising edge iff in_valid && in_ready && !flush; the entry is written at the write pointer and the write pointer advances.
REQ-015 Dequeue SHALL occur on a rising edge iff out_valid && out_ready && !flush; the read pointer advances.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH (DEPTH-1 → 0).
REQ-017 count SHALL increase by 1 on enqueue-only, decrease by 1 on dequeue-only, and stay unchanged on simultaneous enqueue+dequeue or on neither.
REQ-018 in_ready SHALL equal (count < DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-019 When full, a simultaneous dequeue SHALL NOT enable an enqueue in the same cycle; in_ready rises the cycle after the dequeue.
REQ-020 out_valid SHALL equal (count != 0); out_data SHALL equal the entry at the read pointer when out_valid=1 and all-zeros when out_valid=0.
REQ-021 Minimum latency SHALL be 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N when the buffer was empty.
REQ-022 Sustained throughput SHALL be 1 beat/cycle when out_ready=1 continuously and in_valid=1 continuously.
REQ-023 flush SHALL take priority over enqueue and dequeue: at the edge, count←0, pointers←0, and any concurrent handshake is discarded; storage contents need not be cleared.
REQ-024 Entries SHALL leave in arrival order (FIFO); payload bits SHALL pass unmodified.
REQ-025 in_data SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0 (no count underflow).
REQ-026 in_valid held while in_ready=0 SHALL NOT change any state (no overflow).

Reset
REQ-027 While rst=1, the block SHALL asynchronously force count=0, both pointers=0, out_valid=0, out_data=0, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-029 After rst deasserts, the first enqueue SHALL be accepted on the first rising edge with in_valid=1.

Verification (WIDTH=32, DEPTH=2)
REQ-030 The bench SHALL cover this scenario: reset → release, in_valid=1 data=0xA5A5_0001, out_ready=0 → after 1 edge out_valid=1, out_data=0xA5A5_0001, count=1.
REQ-031 The bench SHALL cover this scenario: out_ready=0, push 0x11 then 0x22 → count=2, in_ready=0; a push of 0x33 is held without acceptance; then out_ready=1 for 1 cycle → out_data becomes 0x22, count=1, in_ready=1; 0x33 is accepted the following edge.
REQ-032 The bench SHALL cover this scenario: streaming 0x1..0x10 with in_valid=out_ready=1 → out_data outputs 0x1..0x10 on consecutive cycles, with no bubble after the first, and count held at 1.
REQ-033 The bench SHALL cover this scenario: count=2 with flush=1 and in_valid=1 (0x44) on the same edge → count=0, out_valid=0, out_data=0, and 0x44 is not stored.
REQ-034 The bench SHALL cover this scenario: count=2, rst pulsed between edges → out_valid=0 and count=0 before the next edge; a push of 0x55 afterwards appears alone.
REQ-035 The bench SHALL cover this scenario: pointer wrap, 5 alternating push/pop pairs (0x60..0x64) with out_ready random → output order 0x60..0x64 exactly, and count never exceeds 2 or goes below 0.
